// File: rtl/sseg_scan_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//  - Active-low segment codes: bit 7 is the decimal point, bits 6:0 are g..a.
//  - Encodings for the double-dabble converter FSM.
//  - seg_encode(): maps one BCD nibble to its segment pattern.
package sseg_scan_display_pkg;

  localparam logic [7:0] SSEG_0     = 8'hC0;
  localparam logic [7:0] SSEG_1     = 8'hF9;
  localparam logic [7:0] SSEG_2     = 8'hA4;
  localparam logic [7:0] SSEG_3     = 8'hB0;
  localparam logic [7:0] SSEG_4     = 8'h99;
  localparam logic [7:0] SSEG_5     = 8'h92;
  localparam logic [7:0] SSEG_6     = 8'h82;
  localparam logic [7:0] SSEG_7     = 8'hF8;
  localparam logic [7:0] SSEG_8     = 8'h80;
  localparam logic [7:0] SSEG_9     = 8'h90;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_MINUS = 8'hBF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Nibbles 10..15 cannot come out of a valid conversion; they show '0'.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SSEG_0;
      4'd1:    return SSEG_1;
      4'd2:    return SSEG_2;
      4'd3:    return SSEG_3;
      4'd4:    return SSEG_4;
      4'd5:    return SSEG_5;
      4'd6:    return SSEG_6;
      4'd7:    return SSEG_7;
      4'd8:    return SSEG_8;
      4'd9:    return SSEG_9;
      default: return SSEG_0;
    endcase
  endfunction

endpackage

// File: rtl/sseg_scan_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//  One bit of the captured value is consumed per cycle, so a conversion takes
//  DATA_WIDTH cycles. The result and the overflow flag are committed together on
//  the edge that drops busy; until then the previous result stays visible.
// Ports:
//  clk    in   system clock, rising edge
//  reset  in   asynchronous, active-low reset
//  start  in   conversion request, ignored while busy
//  bin    in   DATA_WIDTH-bit binary value, sampled when start is accepted
//  busy   out  conversion in progress
//  bcd    out  DIGITS packed BCD nibbles, nibble 0 = least significant
//  ovf    out  value did not fit in DIGITS decimal digits
module bin2bcd_seq
  import sseg_scan_display_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bin,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_t                state, state_next;
  logic                  capture, commit, last_shift;
  logic [DATA_WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0]      work, work_adj, work_next;
  logic                  carry, ovf_work;
  logic [CNT_W-1:0]      cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  assign last_shift = (cnt == CNT_W'(DATA_WIDTH - 1));

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHIFT;
          capture    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (last_shift) begin
          state_next = ST_IDLE;
          commit     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

  // One double-dabble step: correct every nibble >= 5, then shift in the next
  // binary bit. Whatever falls out of the top nibble means the value exceeds
  // DIGITS decimal digits.
  always_comb begin
    work_adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
    {carry, work_next} = {work_adj, bin_sr[DATA_WIDTH-1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr   <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_work <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else if (capture) begin
      bin_sr   <= bin;
      work     <= '0;
      cnt      <= '0;
      ovf_work <= 1'b0;
    end else if (state == ST_SHIFT) begin
      bin_sr   <= bin_sr << 1;
      work     <= work_next;
      cnt      <= cnt + 1'b1;
      ovf_work <= ovf_work | carry;
      if (commit) begin
        bcd <= work_next;
        ovf <= ovf_work | carry;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_display.sv
// sseg_scan_display: multiplexed 7-segment driver for address/data readout.
//  A load converts value to BCD (bin2bcd_seq); the committed digits are then
//  scanned one tube at a time, each lit for REFRESH_DIV clocks.
//  Optional build macro SSEG_LEADING_ZERO_BLANK_EN: leading zero digits are
//  blanked (digit 0 never is); not applied while overflow is shown.
// Ports:
//  clk             in   system clock, rising edge
//  reset           in   asynchronous, active-low reset
//  value           in   binary value to display, sampled on an accepted load
//  load            in   conversion request, accepted when busy is low
//  dp_mask         in   decimal point per digit (1 = lit), sampled live
//  busy            out  conversion in progress
//  sseg_indicator  out  active-low segments, [7]=DP, [6:0]=g..a
//  digits          out  one-hot active-high digit enable, bit 0 = rightmost
module sseg_scan_display
  import sseg_scan_display_pkg::*;
#(
  parameter int DATA_WIDTH  = 9,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  busy,
  output logic [7:0]            sseg_indicator,
  output logic [DIGITS-1:0]     digits
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BCD_W-1:0] bcd;
  logic             ovf;
  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] idx, idx_next;
  logic             wrap;
  logic [3:0]       nib;
  logic [7:0]       seg_next;

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIGITS     (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  assign wrap     = (scan_cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // lead_zero[k]: nibble k and every nibble above it are zero.
  logic [DIGITS-1:0] lead_zero;
  always_comb begin
    lead_zero             = '0;
    lead_zero[DIGITS-1]   = (bcd[BCD_W-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (bcd[4*k +: 4] == 4'd0);
    end
  end
`endif

  // Segment pattern for the digit that becomes active on the next wrap, so the
  // enable and the pattern are registered on the same edge.
  always_comb begin
    nib      = bcd[{idx_next, 2'b00} +: 4];
    seg_next = seg_encode(nib);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if ((idx_next != '0) && lead_zero[idx_next]) seg_next = SSEG_BLANK;
`endif
    if (ovf)                seg_next    = SSEG_MINUS;
    if (dp_mask[idx_next])  seg_next[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt       <= '0;
      idx            <= '0;
      digits         <= DIGITS'(1);
      sseg_indicator <= SSEG_BLANK;
    end else if (wrap) begin
      scan_cnt       <= '0;
      idx            <= idx_next;
      digits         <= DIGITS'(1) << idx_next;
      sseg_indicator <= seg_next;
    end else begin
      scan_cnt       <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sseg_scan_display.sv
// Directed bench for sseg_scan_display. Three instances cover the default
// geometry (a), a two-digit display for overflow (b) and a fast scan rate (c).
// Expected segment patterns are written out by hand; blank-enabled builds
// (SSEG_LEADING_ZERO_BLANK_EN) expect FF for leading zero digits.
module tb_sseg_scan_display;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] value_a, value_b, value_c;
  logic       load_a, load_b, load_c;
  logic [3:0] dp_a, dp_c;
  logic [1:0] dp_b;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] seg_a, seg_b, seg_c;
  logic [3:0] dig_a, dig_c;
  logic [1:0] dig_b;

  sseg_scan_display #(.DATA_WIDTH(9), .DIGITS(4), .REFRESH_DIV(8)) dut_a (
    .clk(clk), .reset(reset), .value(value_a), .load(load_a), .dp_mask(dp_a),
    .busy(busy_a), .sseg_indicator(seg_a), .digits(dig_a));

  sseg_scan_display #(.DATA_WIDTH(9), .DIGITS(2), .REFRESH_DIV(8)) dut_b (
    .clk(clk), .reset(reset), .value(value_b), .load(load_b), .dp_mask(dp_b),
    .busy(busy_b), .sseg_indicator(seg_b), .digits(dig_b));

  sseg_scan_display #(.DATA_WIDTH(9), .DIGITS(4), .REFRESH_DIV(3)) dut_c (
    .clk(clk), .reset(reset), .value(value_c), .load(load_c), .dp_mask(dp_c),
    .busy(busy_c), .sseg_indicator(seg_c), .digits(dig_c));

  int         total = 0;
  int         bad = 0;
  logic [7:0] cap_seg [4];
  int         run_err;
  int         wraps;
  int         n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] get_dig(input int which);
    case (which)
      0:       return dig_a;
      1:       return {2'b00, dig_b};
      default: return dig_c;
    endcase
  endfunction

  function automatic logic [7:0] get_seg(input int which);
    case (which)
      0:       return seg_a;
      1:       return seg_b;
      default: return seg_c;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic drive_load(input int which, input logic v, input logic [8:0] val);
    case (which)
      0:       begin value_a = val; load_a = v; end
      1:       begin value_b = val; load_b = v; end
      default: begin value_c = val; load_c = v; end
    endcase
  endtask

  // One-cycle load pulse; returns at the falling edge after it was sampled.
  task automatic pulse_load(input int which, input logic [8:0] val);
    @(negedge clk);
    drive_load(which, 1'b1, val);
    @(negedge clk);
    drive_load(which, 1'b0, val);
  endtask

  // Counts rising edges until busy is low, bounded to 60.
  task automatic wait_idle(input int which, output int cycles);
    cycles = 0;
    while (get_busy(which) && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Lets every digit refresh, then watches two full rotations: records the
  // pattern shown on each digit and flags bad rotation order, non-one-hot
  // enables and dwell times other than rd.
  task automatic scan(input int which, input int nd, input int rd);
    logic [3:0] prev, cur, nxt, last;
    int run, nchg;
    run_err = 0;
    wraps   = 0;
    for (int k = 0; k < 4; k++) cap_seg[k] = 8'h00;
    last = 4'b0001 << (nd - 1);
    repeat (nd * rd) @(posedge clk);
    @(negedge clk);
    prev = get_dig(which);
    run  = 1;
    nchg = 0;
    for (int c = 0; c < 2 * nd * rd; c++) begin
      @(negedge clk);
      cur = get_dig(which);
      if (!$onehot(cur)) run_err++;
      for (int k = 0; k < nd; k++) if (cur[k]) cap_seg[k] = get_seg(which);
      if (cur != prev) begin
        nxt = (prev == last) ? 4'b0001 : (prev << 1);
        if (cur != nxt) run_err++;
        if (prev == last && cur == 4'b0001) wraps++;
        if (nchg > 0 && run != rd) run_err++;
        nchg++;
        run  = 1;
        prev = cur;
      end else begin
        run++;
      end
    end
    if (nchg < nd) run_err++;
  endtask

  initial begin
    value_a = '0; value_b = '0; value_c = '0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    dp_a = '0; dp_b = '0; dp_c = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_digits", dig_a, 4'b0001);
    check("rst_sseg", seg_a, 8'hFF);
    reset = 1'b1;

    // 255 -> 0255, nine busy cycles, 8 clocks per digit
    pulse_load(0, 9'd255);
    check("t2_busy_rise", busy_a, 1'b1);
    wait_idle(0, n);
    check("t2_busy_len", n, 9);
    scan(0, 4, 8);
    check("t2_scan", run_err, 0);
    check("t2_d0", cap_seg[0], 8'h92);
    check("t2_d1", cap_seg[1], 8'h92);
    check("t2_d2", cap_seg[2], 8'hA4);
    check("t2_d3", cap_seg[3], LZ);

    // Reset during a conversion: outputs drop at once, nothing is committed
    pulse_load(0, 9'd7);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t1_busy", busy_a, 1'b0);
    check("t1_digits", dig_a, 4'b0001);
    check("t1_sseg", seg_a, 8'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("t1_idle", busy_a, 1'b0);
    scan(0, 4, 8);
    check("t1_d0", cap_seg[0], 8'hC0);
    check("t1_d1", cap_seg[1], LZ);
    check("t1_d3", cap_seg[3], LZ);

    // Load while busy (including the commit edge) is ignored
    pulse_load(0, 9'd7);
    @(negedge clk);
    drive_load(0, 1'b1, 9'd300);
    wait_idle(0, n);
    drive_load(0, 1'b0, 9'd300);
    repeat (3) @(posedge clk);
    #1;
    check("t3_no_restart", busy_a, 1'b0);
    scan(0, 4, 8);
    check("t3_d0", cap_seg[0], 8'hF8);
    check("t3_d1", cap_seg[1], LZ);
    check("t3_d2", cap_seg[2], LZ);
    check("t3_d3", cap_seg[3], LZ);

    // Decimal point on digit 1 with value 0
    dp_a = 4'b0010;
    pulse_load(0, 9'd0);
    wait_idle(0, n);
    scan(0, 4, 8);
    check("t5_d0", cap_seg[0], 8'hC0);
    check("t5_d1", cap_seg[1], LZ & 8'h7F);
    check("t5_d2", cap_seg[2], LZ);
    dp_a = 4'b0000;

    // Two digits: 100 overflows (DP still honoured), 99 fits
    dp_b = 2'b01;
    pulse_load(1, 9'd100);
    wait_idle(1, n);
    check("t4_busy_len", n, 9);
    scan(1, 2, 8);
    check("t4_scan", run_err, 0);
    check("t4_ovf_d0", cap_seg[0], 8'h3F);
    check("t4_ovf_d1", cap_seg[1], 8'hBF);
    dp_b = 2'b00;
    pulse_load(1, 9'd99);
    wait_idle(1, n);
    scan(1, 2, 8);
    check("t4_99_d0", cap_seg[0], 8'h90);
    check("t4_99_d1", cap_seg[1], 8'h90);

    // Fast scan: rotate every 3 clocks and wrap 1000 -> 0001
    scan(2, 4, 3);
    check("t6_scan", run_err, 0);
    check("t6_wrap", wraps > 0, 1);
    check("t6_d0", cap_seg[0], 8'hC0);
    check("t6_d3", cap_seg[3], LZ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
